// File: rtl/calc_seq_signed.sv
`default_nettype none
// ============================================================================
// Module      : calc_seq_signed
// Description : Sequential signed two's-complement calculator. ADD/SUB finish
//               in one cycle; MUL (shift-and-add) and DIV (restoring) iterate
//               one bit per cycle on operand magnitudes and apply the sign
//               correction on the last iteration. Valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_seq_signed #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     result,
    output logic [WIDTH-1:0]       remainder,
    output logic                   div_by_zero
);

    localparam int                 c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Control state
    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_op;
    logic                 r_direct;     // ADD/SUB or DIV by zero: no iterations
    logic                 r_div_zero;
    logic                 r_neg_res;    // final result must be negated
    logic                 r_neg_rem;    // final remainder must be negated

    // Latched operands and iteration registers
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_mag_a;      // |a| for MUL
    logic [WIDTH-1:0]     r_mag_b;      // |b| for MUL and DIV
    logic [WIDTH-1:0]     r_dvd;        // |a| shifted out MSB first for DIV
    logic [WIDTH-1:0]     r_prem;       // partial remainder magnitude
    logic [WIDTH-1:0]     r_quo;        // quotient magnitude bits so far
    logic [2*WIDTH-1:0]   r_acc;        // product accumulator

    // Registered outputs
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_dbz;

    // Combinational datapath
    logic [WIDTH-1:0]     w_mag_a_in;
    logic [WIDTH-1:0]     w_mag_b_in;
    logic                 w_b_zero;
    logic                 w_accept;
    logic                 w_out_fire;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_sum_ext;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_mul_final;
    logic [WIDTH:0]       w_prem_shift;
    logic [WIDTH:0]       w_prem_diff;
    logic                 w_q_bit;
    logic [WIDTH-1:0]     w_prem_next;
    logic [WIDTH-1:0]     w_quo_mag;
    logic [2*WIDTH-1:0]   w_quo_ext;
    logic [2*WIDTH-1:0]   w_div_final;
    logic [WIDTH-1:0]     w_rem_final;
    logic                 w_unused_bits;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

    assign w_accept   = (r_state == c_ST_IDLE) && in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // Magnitudes are unsigned WIDTH-bit, so the most negative value maps to 2^(WIDTH-1)
    always_comb begin
        w_mag_a_in = a[WIDTH-1] ? (-a) : a;
        w_mag_b_in = b[WIDTH-1] ? (-b) : b;
        w_b_zero   = (b == '0);
    end

    // ADD/SUB at WIDTH+1 bits so the sum can never overflow, then sign-extend
    always_comb begin
        if (r_op == c_OP_SUB) begin
            w_sum = {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b};
        end else begin
            w_sum = {r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b};
        end
        w_sum_ext = {{(WIDTH-1){w_sum[WIDTH]}}, w_sum};
    end

    // One shift-and-add step: AND-gated partial product for multiplier bit r_cnt
    always_comb begin
        w_pp        = {{WIDTH{1'b0}}, (r_mag_a & {WIDTH{r_mag_b[r_cnt]}})} << r_cnt;
        w_acc_next  = r_acc + w_pp;
        w_mul_final = r_neg_res ? (-w_acc_next) : w_acc_next;
    end

    // One restoring-division step; the partial remainder stays below |b|,
    // so the shifted value's top bit is only ever needed by the compare
    always_comb begin
        w_prem_shift = {r_prem, r_dvd[WIDTH-1]};
        w_prem_diff  = w_prem_shift - {1'b0, r_mag_b};
        w_q_bit      = (w_prem_shift >= {1'b0, r_mag_b});
        w_prem_next  = w_q_bit ? w_prem_diff[WIDTH-1:0] : w_prem_shift[WIDTH-1:0];
        w_quo_mag    = {r_quo[WIDTH-2:0], w_q_bit};
        w_quo_ext    = {{WIDTH{1'b0}}, w_quo_mag};
        w_div_final  = r_neg_res ? (-w_quo_ext) : w_quo_ext;
        w_rem_final  = r_neg_rem ? (-w_prem_next) : w_prem_next;
    end

    assign w_unused_bits = ^{w_prem_diff[WIDTH], w_prem_shift[WIDTH], r_quo[WIDTH-1]};

    // Control FSM, iteration registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_op        <= c_OP_ADD;
            r_direct    <= 1'b0;
            r_div_zero  <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_dvd       <= '0;
            r_prem      <= '0;
            r_quo       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op       <= op;
                        r_a        <= a;
                        r_b        <= b;
                        r_mag_a    <= w_mag_a_in;
                        r_mag_b    <= w_mag_b_in;
                        r_dvd      <= w_mag_a_in;
                        r_prem     <= '0;
                        r_quo      <= '0;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_neg_res  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_rem  <= a[WIDTH-1];
                        r_div_zero <= (op == c_OP_DIV) && w_b_zero;
                        r_in_ready <= 1'b0;
                        if ((op == c_OP_ADD) || (op == c_OP_SUB) ||
                            ((op == c_OP_DIV) && w_b_zero)) begin
                            r_direct <= 1'b1;
                            r_state  <= c_ST_DONE;
                        end else begin
                            r_direct <= 1'b0;
                            r_state  <= c_ST_CALC;
                        end
                    end
                end

                c_ST_CALC: begin
                    if (r_op == c_OP_MUL) begin
                        r_acc <= w_acc_next;
                    end else begin
                        r_prem <= w_prem_next;
                        r_quo  <= w_quo_mag;
                        r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    // Last iteration commits the sign-corrected result
                    if (r_cnt == c_CNT_LAST) begin
                        if (r_op == c_OP_MUL) begin
                            r_result    <= w_mul_final;
                            r_remainder <= '0;
                        end else begin
                            r_result    <= w_div_final;
                            r_remainder <= w_rem_final;
                        end
                        r_dbz   <= 1'b0;
                        r_state <= c_ST_DONE;
                    end
                end

                c_ST_DONE: begin
                    if (!r_out_valid) begin
                        // First DONE cycle publishes the result; single-cycle ops compute it here
                        r_out_valid <= 1'b1;
                        if (r_direct) begin
                            if (r_div_zero) begin
                                r_result    <= '0;
                                r_remainder <= r_a;
                                r_dbz       <= 1'b1;
                            end else begin
                                r_result    <= w_sum_ext;
                                r_remainder <= '0;
                                r_dbz       <= 1'b0;
                            end
                        end
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= c_ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
